// File: rtl/uart_rx_core.sv
// UART receiver: oversamples the serial line at PRESCALE clocks per bit, majority-votes
// three mid-bit samples, checks start/parity/stop and emits a data-valid or error pulse.
module uart_rx_core #(
  parameter int   DATA_WIDTH = 8,
  parameter logic START_BIT  = 1'b0,
  parameter logic STOP_BIT   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic [2:0]            dbg_state
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [5:0]            p_q, edge_cnt, half;
  logic [BW-1:0]         bit_cnt;
  logic                  par_en_q, par_typ_q, par_err_q;
  logic                  s0, s1, s2, maj;
  logic                  armed;
  logic [DATA_WIDTH-1:0] shift;
  logic                  edge_last, decide, bit_last, start_det, exp_par, stop_good;

  assign half      = {1'b0, p_q[5:1]};
  assign edge_last = (edge_cnt == p_q - 6'd1);
  assign decide    = (edge_cnt == half + 6'd2);
  assign bit_last  = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign maj       = (s0 & s1) | (s0 & s2) | (s1 & s2);
  // armed is only set once the line has been seen idle, so a held-low line never restarts a frame
  assign start_det = (state == IDLE) && armed && (RX_IN == START_BIT);
  assign exp_par   = par_typ_q ? ~^shift : ^shift;
  assign stop_good = (maj == STOP_BIT);
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_det) state_nxt = START;
      START: begin
        if (decide && (maj != START_BIT)) state_nxt = IDLE;
        else if (edge_last)               state_nxt = DATA;
      end
      DATA:   if (edge_last && bit_last) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (edge_last) state_nxt = STOP;
      STOP:   if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_q        <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      armed      <= 1'b0;
      shift      <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state == IDLE && RX_IN == STOP_BIT) armed <= 1'b1;
      if (start_det) begin
        p_q       <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_err_q <= 1'b0;
        edge_cnt  <= 6'd1;
        bit_cnt   <= '0;
      end else if (state != IDLE) begin
        edge_cnt <= (edge_last || state_nxt == IDLE) ? 6'd0 : edge_cnt + 6'd1;
        if (edge_cnt == half - 6'd1) s0 <= RX_IN;
        if (edge_cnt == half)        s1 <= RX_IN;
        if (edge_cnt == half + 6'd1) s2 <= RX_IN;
        if (state_nxt == IDLE) armed <= (maj == STOP_BIT);
        if (state == DATA && decide) shift <= {maj, shift[DATA_WIDTH-1:1]};
        if (state == DATA && edge_last) bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
        if (state == PARITY && decide) par_err_q <= (maj != exp_par);
        if (state == STOP && decide) begin
          DATA_VALID <= stop_good && !par_err_q;
          STP_ERR    <= !stop_good;
          PAR_ERR    <= par_err_q;
          if (stop_good && !par_err_q) P_DATA <= shift;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: table of frames checked through an event scoreboard,
// plus hand sequences for glitch, break, reset-abort and latency.
module tb_uart_rx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd16;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  logic [7:0] exp_pdata = 8'h00;
  // entry = {valid, par_err, stp_err, data}
  logic [10:0] exp_q[$];

  uart_rx_core dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every pulse cycle pops one expected event
  always @(negedge CLK) begin
    if (RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      checks++;
      if (DATA_VALID) last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got v/p/s=%b%b%b expected none", DATA_VALID, PAR_ERR, STP_ERR);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({DATA_VALID, PAR_ERR, STP_ERR} !== e[10:8]) begin
          errors++;
          $display("FAIL pulse_kind: got %b expected %b", {DATA_VALID, PAR_ERR, STP_ERR}, e[10:8]);
        end else if (DATA_VALID && P_DATA !== e[7:0]) begin
          errors++;
          $display("FAIL pulse_data: got %h expected %h", P_DATA, e[7:0]);
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int p, input logic flip, output int first_cyc);
    for (int c = 0; c < p; c++) begin
      @(posedge CLK); #1;
      RX_IN = (flip && c == p / 2) ? ~b : b;
      if (c == 0) first_cyc = cyc;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [5:0] p, input logic pe, input logic pt, input logic [7:0] d,
                            input logic bad_par, input logic stop, input logic flip, output int start_cyc);
    int dummy;
    logic par;
    PRESCALE = p; PAR_EN = pe; PAR_TYP = pt;
    par = (pt ? ~^d : ^d) ^ bad_par;
    drive_bit(1'b0, int'(p), flip, start_cyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], int'(p), flip, dummy);
    if (pe) drive_bit(par, int'(p), flip, dummy);
    drive_bit(stop, int'(p), flip, dummy);
  endtask

  typedef struct packed {
    logic [5:0] p;
    logic       pe;
    logic       pt;
    logic [7:0] d;
    logic       bad_par;
    logic       stop;
    logic       flip;
    logic       gap;
    logic [2:0] kind;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int sc, dummy, lat;
    vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100};
    vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100};
    vecs[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010};
    vecs[3] = '{6'd32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
    vecs[4] = '{6'd32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100};
    vecs[5] = '{6'd8,  1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[6] = '{6'd16, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011};
    vecs[7] = '{6'd8,  1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
    vecs[8] = '{6'd32, 1'b0, 1'b0, 8'h6E, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100};

    // reset state
    #1;
    check("reset_pdata", 32'(P_DATA), 32'h0);
    check("reset_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    #20 RST = 1'b1;
    idle_cycles(10);

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].kind, vecs[i].d});
      if (vecs[i].kind == 3'b100) exp_pdata = vecs[i].d;
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].bad_par,
                 vecs[i].stop, vecs[i].flip, sc);
      if (vecs[i].gap) idle_cycles(int'(vecs[i].p));
      check($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'h0);
      check($sformatf("vec%0d_pdata", i), 32'(P_DATA), 32'(exp_pdata));
      if (vecs[i].kind == 3'b100) begin
        lat = (9 + int'(vecs[i].pe)) * int'(vecs[i].p) + int'(vecs[i].p) / 2 + 3;
        check($sformatf("vec%0d_latency", i), 32'(last_valid_cyc - sc), 32'(lat));
      end
    end

    // 3-clock glitch on idle line, then a valid frame
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge CLK); #1; RX_IN = 1'b0; end
    idle_cycles(40);
    check("glitch_state", 32'(dbg_state), 32'h0);
    check("glitch_no_pulse", 32'(exp_q.size()), 32'h0);
    exp_q.push_back({3'b100, 8'h55}); exp_pdata = 8'h55;
    send_frame(6'd16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, sc);
    idle_cycles(16);
    check("glitch_next_pdata", 32'(P_DATA), 32'(exp_pdata));
    check("glitch_next_drained", 32'(exp_q.size()), 32'h0);

    // bad stop on 0x81, then break of two frames: exactly one more stop error
    exp_q.push_back({3'b001, 8'h81});
    send_frame(6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, sc);
    idle_cycles(8);
    exp_q.push_back({3'b001, 8'h00});
    for (int c = 0; c < 160; c++) begin @(posedge CLK); #1; RX_IN = 1'b0; end
    check("break_drained", 32'(exp_q.size()), 32'h0);
    check("break_state", 32'(dbg_state), 32'h0);
    check("break_pdata", 32'(P_DATA), 32'(exp_pdata));
    idle_cycles(20);

    // reset in the middle of 0x12
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    drive_bit(1'b0, 8, 1'b0, dummy);
    drive_bit(1'b0, 8, 1'b0, dummy);
    drive_bit(1'b1, 8, 1'b0, dummy);
    drive_bit(1'b0, 8, 1'b0, dummy);
    @(posedge CLK); #2;
    RST = 1'b0; exp_pdata = 8'h00;
    #1;
    check("rst_mid_pdata", 32'(P_DATA), 32'h0);
    check("rst_mid_state", 32'(dbg_state), 32'h0);
    check("rst_mid_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    for (int c = 0; c < 30; c++) begin @(posedge CLK); #1; RX_IN = 1'b0; end
    check("rst_low_line_idle", 32'(dbg_state), 32'h0);
    idle_cycles(10);
    exp_q.push_back({3'b100, 8'h34}); exp_pdata = 8'h34;
    send_frame(6'd8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, sc);
    idle_cycles(8);
    check("rst_after_pdata", 32'(P_DATA), 32'(exp_pdata));
    exp_q.push_back({3'b100, 8'h34});
    send_frame(6'd16, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b1, sc);
    idle_cycles(16);
    check("flip_pdata", 32'(P_DATA), 32'(exp_pdata));
    check("final_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
